hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Register-file hazard controller for the 5-stage stall-based pipeline.
- Keeps a per-register pending-write bitmask covering every instruction issued from decode but not yet written back.
- Drives the decode stall so that decode never reads a stale operand (RAW) and never reorders writes to the same register (WAW).
- Also keeps stall statistics and a stuck-stall watchdog.

Parameters:
CORE, 0, core index used in report output
NUM_REGS, 32, number of architectural registers
SEL_BITS, 5, register select width
CNT_BITS, 32, stall statistics counter width
TIMEOUT_CYCLES, 1024, consecutive stall cycles before hazard_timeout asserts; 0 disables the watchdog

Ports:
clock  input  1  core clock, rising edge
reset  input  1  asynchronous reset, active-high
issue_valid  input  1  decode holds a valid instruction that wants to move to execute
issue_writes  input  1  that instruction writes rd
issue_rd  input  SEL_BITS  destination register of the decode instruction
uses_rs1  input  1  instruction reads rs1
uses_rs2  input  1  instruction reads rs2
rs1  input  SEL_BITS  source select 1 (same value the decoder presents to the register file)
rs2  input  SEL_BITS  source select 2
flush  input  1  decode instruction is squashed this cycle
wb_valid  input  1  register-file write enable from writeback
wb_reg  input  SEL_BITS  register-file write select
report  input  1  enables per-cycle $display
stall  output  1  hold fetch/decode; inject bubble into execute
pending  output  NUM_REGS  current pending-write bitmask
stall_cycles  output  CNT_BITS  total cycles with stall=1
hazard_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset values:
  - pending = 0, stall_cycles = 0, hazard_timeout = 0.
  - Consecutive-stall counter = 0.
  - stall is combinational and is 0 while pending = 0.
- Register x0 is never marked pending and never causes a hazard.
- wb_clear = one-hot(wb_reg) when wb_valid and wb_reg != 0; otherwise 0.
- pend_eff = pending. With the optional feature enabled, pend_eff = pending & ~wb_clear (see Optional Feature).
- stall (combinational, same cycle) is 1 only when all of the following hold:
  - issue_valid = 1 and flush = 0;
  - at least one hazard is present:
    - uses_rs1, rs1 != 0, and pend_eff[rs1] = 1 (RAW on rs1); or
    - uses_rs2, rs2 != 0, and pend_eff[rs2] = 1 (RAW on rs2); or
    - issue_writes, issue_rd != 0, and pend_eff[issue_rd] = 1 (WAW).
- Issue accepted when issue_valid = 1, flush = 0 and stall = 0.
  - An accepted issue with issue_writes = 1 and issue_rd != 0 sets pending[issue_rd] at the next rising edge.
- Update at each rising edge: pending <= (pending & ~wb_clear) | issue_set.
  - If set and clear target the same bit, set wins.
- Writeback to a register that is not pending: no effect, no error.
- flush = 1: stall forced to 0 and no bit is set; writeback clearing proceeds normally.
- stall_cycles increments on each rising edge where stall = 1 and saturates at all-ones.
- Watchdog:
  - Consecutive counter increments while stall = 1 and clears to 0 on any cycle with stall = 0.
  - When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES > 0), hazard_timeout is set at that edge.
  - hazard_timeout stays at 1 until reset.
  - The consecutive counter saturates at TIMEOUT_CYCLES.
- Reset asserted mid-operation clears all state immediately (asynchronous). Any in-flight writebacks after reset are ignored because the target bits are already 0.
- report = 1: $display each cycle of core, cycle count, pending (hex), stall, the hazard source (rs1/rs2/rd), stall_cycles and hazard_timeout.

Optional Feature:
- Macro: HAZARD_WB_BYPASS_EN.
- Defined:
  - The register file is write-through, so a writeback in the same cycle satisfies the hazard.
  - pend_eff masks wb_clear, and stall drops in the same cycle as the matching writeback.
- Undefined:
  - pend_eff = pending.
  - stall drops one cycle after the matching writeback, when the pending bit has cleared.

Test Plan:
1. RAW on a load: reset; accept issue rd=5 (issue_writes=1) -> pending=0x00000020 next cycle. Then present uses_rs1=1, rs1=5 -> stall=1. Apply wb_valid=1, wb_reg=5 -> pending=0 after the edge; stall_cycles equals the number of stalled cycles (e.g. 3).
2. Bypass: pending[5]=1, rs2=5, uses_rs2=1, wb_reg=5 in cycle N -> with HAZARD_WB_BYPASS_EN, stall=0 in cycle N; without the macro, stall=1 in cycle N and 0 in N+1.
3. x0 handling: issue rd=0 accepted -> pending stays 0. uses_rs1=1, rs1=0 with any pending value -> stall=0. wb_reg=0 -> no change.
4. WAW: pending[7]=1, issue_writes=1, issue_rd=7, uses_rs1=uses_rs2=0 -> stall=1 until wb_reg=7; then the bit is re-set by the accepted issue (set wins on the same-cycle bypass case).
5. Watchdog with TIMEOUT_CYCLES=8: hold a RAW stall for 8 cycles -> hazard_timeout=1 at the 8th edge; it stays 1 after the writeback releases stall. flush=1 during the stall -> stall=0 and the consecutive counter resets.
6. Async reset mid-stall: pending=0x00000880 with stall=1; assert reset between edges -> pending=0, stall=0, stall_cycles=0, hazard_timeout=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register-file RAW/WAW hazard scoreboard with decode stall, stall statistics and a stuck-stall watchdog.
// Optional macro HAZARD_WB_BYPASS_EN: a same-cycle writeback satisfies the hazard (write-through register file).
module hazard_scoreboard #(
    parameter int CORE           = 0,
    parameter int NUM_REGS       = 32,
    parameter int SEL_BITS       = 5,
    parameter int CNT_BITS       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_writes,
    input  logic [SEL_BITS-1:0] issue_rd,
    input  logic                uses_rs1,
    input  logic                uses_rs2,
    input  logic [SEL_BITS-1:0] rs1,
    input  logic [SEL_BITS-1:0] rs2,
    input  logic                flush,
    input  logic                wb_valid,
    input  logic [SEL_BITS-1:0] wb_reg,
    input  logic                report,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_BITS-1:0] stall_cycles,
    output logic                hazard_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES);

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_BITS-1:0] sel);
        onehot      = '0;
        onehot[sel] = 1'b1;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        sat_inc = (&v) ? v : v + CNT_BITS'(1);
    endfunction

    logic [NUM_REGS-1:0] wb_clear;
    logic [NUM_REGS-1:0] pend_eff;
    logic [NUM_REGS-1:0] issue_set;
    logic                haz_rs1;
    logic                haz_rs2;
    logic                haz_rd;
    logic                accept;
    logic [CW-1:0]       consec;

    always_comb begin
        wb_clear = '0;
        if (wb_valid && wb_reg != '0)
            wb_clear = onehot(wb_reg);
    end

`ifdef HAZARD_WB_BYPASS_EN
    assign pend_eff = pending & ~wb_clear;
`else
    assign pend_eff = pending;
`endif

    // x0 is hardwired to zero, so it can never be the subject of a hazard.
    always_comb begin
        haz_rs1   = uses_rs1 && (rs1 != '0) && pend_eff[rs1];
        haz_rs2   = uses_rs2 && (rs2 != '0) && pend_eff[rs2];
        haz_rd    = issue_writes && (issue_rd != '0) && pend_eff[issue_rd];
        stall     = issue_valid && !flush && (haz_rs1 || haz_rs2 || haz_rd);
        accept    = issue_valid && !flush && !stall;
        issue_set = '0;
        if (accept && issue_writes && issue_rd != '0)
            issue_set = onehot(issue_rd);
    end

    // Set is OR-ed after the clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending        <= '0;
            stall_cycles   <= '0;
            consec         <= '0;
            hazard_timeout <= 1'b0;
        end else begin
            pending <= (pending & ~wb_clear) | issue_set;
            if (stall)
                stall_cycles <= sat_inc(stall_cycles);
            if (!stall)
                consec <= '0;
            else if (consec != TLIM)
                consec <= consec + CW'(1);
            if (TIMEOUT_CYCLES > 0 && stall && consec == TLIM - CW'(1))
                hazard_timeout <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    logic [31:0] cycle_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cycle_count <= '0;
        else
            cycle_count <= cycle_count + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (report)
            $display("core%0d cyc=%0d pending=%h stall=%0b src(rs1,rs2,rd)=%0b%0b%0b stall_cycles=%0d timeout=%0b",
                     CORE, cycle_count, pending, stall, haz_rs1, haz_rs2, haz_rd,
                     stall_cycles, hazard_timeout);
    end
`endif

endmodule
